fetch_unit: RTL

- PC register and instruction-fetch stage of the 16-bit pipelined core.
- Sits directly downstream of the next-PC logic: each cycle it latches that logic's nxt_pc, drives the instruction-memory address and registers the IF/ID pipeline latch.
- The next-PC logic produces no usable target for RET, so this block owns a small return-address stack (RAS): CALL in EX pushes, RET in EX pops and overrides nxt_pc.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_return_addr_stack.sv | 75 +++++++
 rtl/fetch_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: opcode decode helpers shared by the fetch stage and its bench.
// The opcode values come from the shared opcode header (`CALL, `RET). The
// fallback values below are used only when that header has not already been
// read into the compilation unit.
`ifndef CALL
`define CALL 4'hC
`endif
`ifndef RET
`define RET 4'hD
`endif

package fetch_unit_pkg;

    localparam logic [3:0] OP_CALL = `CALL;
    localparam logic [3:0] OP_RET  = `RET;

    // True when the opcode field of instr matches op.
    function automatic logic is_op(input logic [15:0] instr, input logic [3:0] op);
        return instr[15:12] == op;
    endfunction

endpackage

// File: rtl/fetch_unit_return_addr_stack.sv
// return_addr_stack: circular return-address stack.
//   clk, rst          : clock, synchronous active-high reset
//   push, pop         : stack operations (never both in one cycle)
//   push_data [15:0]  : return address to push
//   top [15:0]        : most recently pushed entry (meaningless when empty)
//   empty, full       : occupancy flags
//   ovf, unf          : sticky flags, push-while-full / pop-while-empty
// When full, a push overwrites the oldest entry. This works because, with the
// stack full, the write pointer already points at the oldest slot.
module return_addr_stack #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] push_data,
    output logic [15:0] top,
    output logic        empty,
    output logic        full,
    output logic        ovf,
    output logic        unf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]   entry_reg [DEPTH];
    logic [PW-1:0] ptr_reg;      // next free slot
    logic [CW-1:0] count_reg;
    logic          ovf_reg;
    logic          unf_reg;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign top   = entry_reg[ptr_reg - PW'(1)];
    assign ovf   = ovf_reg;
    assign unf   = unf_reg;

    // Storage entries carry no reset: occupancy is tracked by count_reg alone.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rst && push && (ptr_reg == PW'(gi))) begin
                    entry_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else if (push) begin
            ptr_reg <= ptr_reg + PW'(1);
            if (full) begin
                ovf_reg <= 1'b1;
            end else begin
                count_reg <= count_reg + CW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf_reg <= 1'b1;
            end else begin
                ptr_reg   <= ptr_reg - PW'(1);
                count_reg <= count_reg - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, IF/ID pipeline latch and return-address stack.
//   clk, rst          : clock, synchronous active-high reset
//   nxt_pc [15:0]     : next PC from the next-PC logic (ignored while RET is in EX)
//   ex_instr [15:0]   : instruction in EX; CALL pushes pc+1, RET pops into pc
//   stall             : freezes PC, IF/ID latch and the RAS
//   imem_data [15:0]  : instruction word read asynchronously at imem_addr
//   pc, imem_addr     : current fetch PC (imem_addr is the same value)
//   if_instr, if_pc   : IF/ID latched instruction and its PC
//   if_valid          : IF/ID latch holds a real instruction
//   ras_ovf, ras_unf  : sticky RAS overflow / underflow
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          RAS_DEPTH = 4,
    parameter logic [15:0] RESET_PC  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] nxt_pc,
    input  logic [15:0] ex_instr,
    input  logic        stall,
    input  logic [15:0] imem_data,
    output logic [15:0] pc,
    output logic [15:0] imem_addr,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic        if_valid,
    output logic        ras_ovf,
    output logic        ras_unf
);

    logic [15:0] pc_reg;
    logic [15:0] if_instr_reg;
    logic [15:0] if_pc_reg;
    logic        if_valid_reg;

    logic        call_in_ex;
    logic        ret_in_ex;
    logic        ras_push;
    logic        ras_pop;
    logic [15:0] ras_top;
    logic        ras_empty;
    logic        ras_full;
    logic [15:0] sel_pc;
    logic        unused_sigs;

    assign call_in_ex = is_op(ex_instr, OP_CALL);
    assign ret_in_ex  = is_op(ex_instr, OP_RET);

    // A stalled CALL/RET is deferred to its first unstalled cycle.
    assign ras_push = call_in_ex && !stall;
    assign ras_pop  = ret_in_ex && !stall;

    // On RET nxt_pc is never selected (it may be X). An empty stack returns
    // RESET_PC rather than a stale entry.
    always_comb begin
        sel_pc = nxt_pc;
        if (ret_in_ex) begin
            sel_pc = ras_empty ? RESET_PC : ras_top;
        end
    end

    return_addr_stack #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_data(pc_reg + 16'd1),
        .top      (ras_top),
        .empty    (ras_empty),
        .full     (ras_full),
        .ovf      (ras_ovf),
        .unf      (ras_unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            if_instr_reg <= 16'h0000;
            if_pc_reg    <= 16'h0000;
            if_valid_reg <= 1'b0;
        end else if (!stall) begin
            pc_reg       <= sel_pc;
            if_instr_reg <= imem_data;
            if_pc_reg    <= pc_reg;
            if_valid_reg <= 1'b1;
        end
    end

    assign pc        = pc_reg;
    assign imem_addr = pc_reg;
    assign if_instr  = if_instr_reg;
    assign if_pc     = if_pc_reg;
    assign if_valid  = if_valid_reg;

    // Operand bits of ex_instr and the full flag are not needed by this stage.
    assign unused_sigs = ^{ex_instr[11:0], ras_full};

endmodule
